// File: rtl/axi_rd_data_chan_tx.sv
// AXI slave read-data channel transmitter: queues {id,len,err} burst commands and frames memory words into R beats.
// Define AXI_RD_SKID_EN for a 2-entry skid output buffer that keeps src_ready free of any combinational rready path.
module axi_rd_data_chan_tx #(
  parameter int ID_MAX_WIDTH = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int LEN_WIDTH    = 4,
  parameter int CMD_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ID_MAX_WIDTH-1:0] cmd_id,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    cmd_err,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [DATA_WIDTH-1:0]   src_data,
  output logic [ID_MAX_WIDTH-1:0] rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    busy
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(CMD_DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? 2'b10 : 2'b00;
  endfunction

  logic [ID_MAX_WIDTH-1:0] fifo_id  [CMD_DEPTH];
  logic [LEN_WIDTH-1:0]    fifo_len [CMD_DEPTH];
  logic                    fifo_err [CMD_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W:0]          fill;
  logic                    empty;
  logic                    full;
  logic                    push;
  logic                    pop;

  logic [0:0]              state;
  logic [ID_MAX_WIDTH-1:0] cur_id;
  logic [LEN_WIDTH-1:0]    cur_len;
  logic                    cur_err;
  logic [LEN_WIDTH-1:0]    cnt;

  logic                    src_hs;
  logic                    last_load;
  logic [1:0]              beat_resp;
  logic                    beat_last;

  assign empty     = (fill == '0);
  assign full      = (fill == FULL_CNT);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;

  assign src_hs    = src_valid && src_ready;
  assign beat_last = (cnt == cur_len);
  assign beat_resp = resp_of(cur_err);
  assign last_load = src_hs && beat_last;
  // A finishing burst hands straight over to the next queued command, so no idle cycle between bursts.
  assign pop       = !empty && ((state == IDLE) || last_load);

  assign busy = (state != IDLE) || !empty || rvalid;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr]  <= cmd_id;
      fifo_len[wr_ptr] <= cmd_len;
      fifo_err[wr_ptr] <= cmd_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cur_id  <= '0;
      cur_len <= '0;
      cur_err <= 1'b0;
      cnt     <= '0;
    end else if (pop) begin
      state   <= BURST;
      cur_id  <= fifo_id[rd_ptr];
      cur_len <= fifo_len[rd_ptr];
      cur_err <= fifo_err[rd_ptr];
      cnt     <= '0;
    end else if (last_load) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (src_hs) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef AXI_RD_SKID_EN
  logic                    skid_vld;
  logic [ID_MAX_WIDTH-1:0] skid_id;
  logic [DATA_WIDTH-1:0]   skid_data;
  logic [1:0]              skid_resp;
  logic                    skid_last;

  // Only register outputs feed src_ready; a stalled beat parks in the skid entry.
  assign src_ready = (state == BURST) && !skid_vld;

  always_ff @(posedge clk) begin
    if (src_hs && rvalid && !rready) begin
      skid_id   <= cur_id;
      skid_data <= src_data;
      skid_resp <= beat_resp;
      skid_last <= beat_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid   <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
      rresp    <= 2'b00;
      rlast    <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!rvalid || rready) begin
      if (skid_vld) begin
        rvalid   <= 1'b1;
        rid      <= skid_id;
        rdata    <= skid_data;
        rresp    <= skid_resp;
        rlast    <= skid_last;
        skid_vld <= 1'b0;
      end else if (src_hs) begin
        rvalid <= 1'b1;
        rid    <= cur_id;
        rdata  <= src_data;
        rresp  <= beat_resp;
        rlast  <= beat_last;
      end else begin
        rvalid <= 1'b0;
      end
    end else if (src_hs) begin
      skid_vld <= 1'b1;
    end
  end
`else
  assign src_ready = (state == BURST) && (!rvalid || rready);

  // Single output stage: load and drain may share the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rid    <= '0;
      rdata  <= '0;
      rresp  <= 2'b00;
      rlast  <= 1'b0;
    end else if (src_hs) begin
      rvalid <= 1'b1;
      rid    <= cur_id;
      rdata  <= src_data;
      rresp  <= beat_resp;
      rlast  <= beat_last;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_data_chan_tx.sv
// Bench for axi_rd_data_chan_tx: vector table, directed corner sequences and a randomized run
// against a beat-stream reference model built from accepted commands and consumed source words.
module tb_axi_rd_data_chan_tx;
  localparam int IDW   = 12;
  localparam int DW    = 32;
  localparam int LW    = 4;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [IDW-1:0] cmd_id;
  logic [LW-1:0]  cmd_len;
  logic           cmd_err;
  logic           src_valid;
  logic           src_ready;
  logic [DW-1:0]  src_data;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;
  logic           busy;

  axi_rd_data_chan_tx #(
    .ID_MAX_WIDTH(IDW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .CMD_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len), .cmd_err(cmd_err),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [LW-1:0]  len;
    logic           err;
  } cmd_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [LW-1:0]  len;
    logic           err;
    int             rmode;
    logic [DW-1:0]  base;
    int             exp_beats;
    logic [1:0]     exp_resp;
    logic [DW-1:0]  exp_last_data;
    int             exp_lat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // reference model state
  cmd_t          mq[$];
  logic [DW-1:0] sq[$];
  int            bi = 0;
  int            cyc = 0;
  int            src_cnt = 0;
  bit            src_take = 0, cmd_take = 0, src_took = 0, cmd_took = 0;
  bit            hold = 0;
  logic          prev_rv = 1'b0;
  logic [IDW-1:0] h_id;
  logic [DW-1:0]  h_data;
  logic [1:0]     h_resp;
  logic           h_last;

  // observation logs
  int             acc_cyc_q[$];
  int             acc_src_q[$];
  int             rise_q[$];
  logic [DW-1:0]  ob_data[$];
  logic [IDW-1:0] ob_id[$];
  logic [1:0]     ob_resp[$];
  logic           ob_last[$];
  int             ob_cyc[$];

  int src_mode = 0;
  int rr_mode  = 3;
  bit rnd_data = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Samples at the falling edge; every handshake seen here completes at the next rising edge.
  task automatic mon();
    bit         have;
    logic [1:0] e_resp;
    logic       e_last;
    if (rst) begin
      mq.delete();
      sq.delete();
      bi = 0;
      hold = 0;
      src_take = 0;
      cmd_take = 0;
      prev_rv = 1'b0;
    end else begin
      if (hold)
        check("hold_stable", 64'({rvalid, rid, rdata, rresp, rlast}),
              64'({1'b1, h_id, h_data, h_resp, h_last}));
      if (rvalid && !prev_rv) rise_q.push_back(cyc);
      if (rvalid && rready) begin
        have = (mq.size() > 0) && (sq.size() > 0);
        check("beat_expected", 64'(have), 64'(1));
        if (have) begin
          e_resp = mq[0].err ? 2'b10 : 2'b00;
          e_last = (bi == int'(mq[0].len));
          check("beat", 64'({rid, rdata, rresp, rlast}), 64'({mq[0].id, sq[0], e_resp, e_last}));
          void'(sq.pop_front());
          if (e_last) begin
            void'(mq.pop_front());
            bi = 0;
          end else begin
            bi++;
          end
        end
        ob_data.push_back(rdata);
        ob_id.push_back(rid);
        ob_resp.push_back(rresp);
        ob_last.push_back(rlast);
        ob_cyc.push_back(cyc + 1);
      end
      cmd_take = cmd_valid && cmd_ready;
      if (cmd_take) begin
        mq.push_back('{cmd_id, cmd_len, cmd_err});
        acc_cyc_q.push_back(cyc + 1);
        acc_src_q.push_back(src_cnt);
      end
      src_take = src_valid && src_ready;
      if (src_take) begin
        sq.push_back(src_data);
        src_cnt++;
      end
      hold   = rvalid && !rready;
      h_id   = rid;
      h_data = rdata;
      h_resp = rresp;
      h_last = rlast;
      prev_rv = rvalid;
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
    src_took = src_take;
    cmd_took = cmd_take;
    if (src_took) src_data = rnd_data ? $urandom : src_data + 32'd1;
    case (src_mode)
      0:       src_valid = 1'b0;
      1:       src_valid = 1'b1;
      default: src_valid = 1'($urandom_range(0, 1));
    endcase
    case (rr_mode)
      0:       rready = 1'b1;
      1:       rready = !rready;
      2:       rready = 1'($urandom_range(0, 1));
      default: rready = 1'b0;
    endcase
  endtask

  task automatic push_cmd(input logic [IDW-1:0] id, input logic [LW-1:0] len, input logic err);
    bit took = 0;
    cmd_id = id;
    cmd_len = len;
    cmd_err = err;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !took; i++) begin
      step();
      took = cmd_took;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 64'(took), 64'(1));
  endtask

  task automatic wait_beats(input int b0, input int n, input int budget);
    for (int i = 0; i < budget && (ob_data.size() - b0) < n; i++) step();
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (busy || rvalid); i++) step();
    check("idle", 64'(busy), 64'(0));
  endtask

  vec_t vecs[6];

  initial begin
    int b0, c0, r0, lat, k, s0, total;
    logic [1:0] resp_or;
    logic [2:0] lasts3;

    vecs[0] = '{12'h05A, 4'd3,  1'b0, 0, 32'h100, 4,  2'b00, 32'h103, 2};
    vecs[1] = '{12'h05A, 4'd3,  1'b0, 1, 32'h100, 4,  2'b00, 32'h103, 2};
    vecs[2] = '{12'h03C, 4'd1,  1'b1, 0, 32'h200, 2,  2'b10, 32'h201, 2};
    vecs[3] = '{12'h03D, 4'd1,  1'b0, 0, 32'h300, 2,  2'b00, 32'h301, 2};
    vecs[4] = '{12'h007, 4'd0,  1'b0, 1, 32'h400, 1,  2'b00, 32'h400, 2};
    vecs[5] = '{12'hFFF, 4'd15, 1'b1, 2, 32'h500, 16, 2'b10, 32'h50F, 2};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_id = '0;
    cmd_len = '0;
    cmd_err = 1'b0;
    src_valid = 1'b0;
    src_data = '0;
    rready = 1'b0;

    repeat (3) step();
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_rlast", 64'(rlast), 64'(0));
    check("rst_rid", 64'(rid), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_rresp", 64'(rresp), 64'(0));
    check("rst_src_ready", 64'(src_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    rst = 1'b0;
    rr_mode = 0;
    step();
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // table-driven single bursts
    for (int i = 0; i < 6; i++) begin
      wait_idle(100);
      rr_mode = vecs[i].rmode;
      rready = 1'b1;
      src_mode = 1;
      src_valid = 1'b1;
      rnd_data = 0;
      src_data = vecs[i].base;
      b0 = ob_data.size();
      c0 = acc_cyc_q.size();
      r0 = rise_q.size();
      push_cmd(vecs[i].id, vecs[i].len, vecs[i].err);
      wait_beats(b0, vecs[i].exp_beats, 200);
      rr_mode = 0;
      wait_idle(100);
      check($sformatf("v%0d_beats", i), 64'(ob_data.size() - b0), 64'(vecs[i].exp_beats));
      if (ob_data.size() - b0 >= vecs[i].exp_beats) begin
        k = 0;
        resp_or = 2'b00;
        for (int j = 0; j < vecs[i].exp_beats; j++) begin
          k += int'(ob_last[b0 + j]);
          resp_or |= ob_resp[b0 + j];
        end
        check($sformatf("v%0d_rlast_count", i), 64'(k), 64'(1));
        check($sformatf("v%0d_final_rlast", i), 64'(ob_last[b0 + vecs[i].exp_beats - 1]), 64'(1));
        check($sformatf("v%0d_resp", i), 64'(resp_or), 64'(vecs[i].exp_resp));
        check($sformatf("v%0d_first_data", i), 64'(ob_data[b0]), 64'(vecs[i].base));
        check($sformatf("v%0d_last_data", i), 64'(ob_data[b0 + vecs[i].exp_beats - 1]),
              64'(vecs[i].exp_last_data));
      end
      lat = (rise_q.size() > r0 && acc_cyc_q.size() > c0) ? rise_q[r0] - acc_cyc_q[c0] : -1;
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
    end

    // back-to-back bursts with no idle cycle between them
    wait_idle(100);
    src_mode = 0;
    src_valid = 1'b0;
    rr_mode = 0;
    push_cmd(12'd1, 4'd0, 1'b0);
    push_cmd(12'd2, 4'd1, 1'b0);
    step();
    step();
    b0 = ob_data.size();
    src_data = 32'h600;
    src_mode = 1;
    src_valid = 1'b1;
    wait_beats(b0, 3, 50);
    wait_idle(50);
    check("b2b_beats", 64'(ob_data.size() - b0), 64'(3));
    if (ob_data.size() - b0 >= 3) begin
      lasts3 = {ob_last[b0], ob_last[b0 + 1], ob_last[b0 + 2]};
      check("b2b_rlast_pattern", 64'(lasts3), 64'(3'b101));
      check("b2b_no_bubble", 64'(ob_cyc[b0 + 2] - ob_cyc[b0]), 64'(2));
      check("b2b_ids", 64'({ob_id[b0], ob_id[b0 + 1], ob_id[b0 + 2]}), 64'({12'd1, 12'd2, 12'd2}));
    end

    // command FIFO full: 1 in flight plus DEPTH queued, the next held off
    wait_idle(100);
    src_mode = 0;
    src_valid = 1'b0;
    rr_mode = 0;
    b0 = ob_data.size();
    c0 = acc_cyc_q.size();
    k = 0;
    cmd_id = 12'h20;
    cmd_len = 4'd1;
    cmd_err = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cmd_took) begin
        k++;
        cmd_id = 12'(12'h20 + k);
        cmd_len = 4'd0;
      end
    end
    check("full_accepted", 64'(acc_cyc_q.size() - c0), 64'(DEPTH + 1));
    check("full_cmd_ready", 64'(cmd_ready), 64'(0));
    s0 = src_cnt;
    src_mode = 1;
    src_valid = 1'b1;
    for (int i = 0; i < 40 && k < DEPTH + 2; i++) begin
      step();
      if (cmd_took) k++;
    end
    cmd_valid = 1'b0;
    check("full_sixth_accepted", 64'(k), 64'(DEPTH + 2));
    if (acc_src_q.size() > c0 + DEPTH + 1)
      check("full_sixth_after_first_burst", 64'(acc_src_q[c0 + DEPTH + 1] - s0), 64'(2));
    wait_idle(100);
    check("full_total_beats", 64'(ob_data.size() - b0), 64'(7));

    // reset in the middle of a burst
    wait_idle(100);
    src_mode = 1;
    src_valid = 1'b1;
    rr_mode = 0;
    b0 = ob_data.size();
    push_cmd(12'd9, 4'd3, 1'b0);
    wait_beats(b0, 2, 50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_rvalid", 64'(rvalid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_rdata", 64'(rdata), 64'(0));
    b0 = ob_data.size();
    push_cmd(12'd3, 4'd0, 1'b0);
    wait_beats(b0, 1, 50);
    wait_idle(50);
    check("midrst_fresh_beats", 64'(ob_data.size() - b0), 64'(1));
    if (ob_data.size() - b0 >= 1) begin
      check("midrst_fresh_rid", 64'(ob_id[b0]), 64'(3));
      check("midrst_fresh_rlast", 64'(ob_last[b0]), 64'(1));
    end

    // randomized traffic against the reference model
    wait_idle(100);
    src_mode = 2;
    rr_mode = 2;
    rnd_data = 1;
    b0 = ob_data.size();
    total = 0;
    for (int i = 0; i < 40; i++) begin
      cmd_t c;
      c.id  = 12'($urandom);
      c.len = 4'($urandom_range(0, 7));
      c.err = 1'($urandom_range(0, 1));
      total += int'(c.len) + 1;
      push_cmd(c.id, c.len, c.err);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_beats(b0, total, 3000);
    src_mode = 0;
    rr_mode = 0;
    wait_idle(200);
    check("rand_beats", 64'(ob_data.size() - b0), 64'(total));
    check("rand_cmds_drained", 64'(mq.size()), 64'(0));
    check("rand_words_drained", 64'(sq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_data_chan_tx.md
# axi_rd_data_chan_tx

Slave-side AXI read data channel transmitter: the R-channel counterpart of the write data channel. It accepts burst commands (ID, length, error flag) from the slave's address/decode logic, pulls data words from a memory-side valid/ready source, and drives AXI R beats (rid/rdata/rresp/rlast) with correct burst framing. It sits between the slave's read command decoder and the AXI interconnect port.

## Interface
- ID_MAX_WIDTH, 12, width of rid/cmd_id
- DATA_WIDTH, 32, width of rdata/src_data
- LEN_WIDTH, 4, burst length field width; beats = cmd_len+1
- CMD_DEPTH, 4, command FIFO depth, power of two, ≥2
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_id  in  ID_MAX_WIDTH  burst ID
- cmd_len  in  LEN_WIDTH  beats minus one
- cmd_err  in  1  return SLVERR on every beat of burst
- src_valid  in  1  data word offered
- src_ready  out  1  word consumed this cycle
- src_data  in  DATA_WIDTH  data word
- rid  out  ID_MAX_WIDTH  AXI read ID
- rdata  out  DATA_WIDTH  AXI read data
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- rlast  out  1  final beat of burst
- rvalid  out  1  beat valid
- rready  in  1  master accepts beat
- busy  out  1  state≠IDLE or FIFO non-empty or rvalid

## Operation
- Command FIFO, CMD_DEPTH entries of {id,len,err}; push on cmd_valid&&cmd_ready; cmd_ready = !full, 0 while rst high. No pass-through when full.
- FSM states IDLE, BURST. Registers cur_id, cur_len, cur_err, beat counter cnt (LEN_WIDTH).
- IDLE: FIFO non-empty → pop head into cur_*, cnt←0, → BURST.
- BURST: src_ready = output slot free. On src handshake: load rdata←src_data, rid←cur_id, rresp←cur_err?2'b10:2'b00, rlast←(cnt==cur_len), rvalid←1, cnt←cnt+1.
- Last beat loaded: FIFO non-empty → pop next, cnt←0, stay BURST (no bubble); else → IDLE.
- Output slot: rvalid clears on rready when no new beat loads; load and drain may coincide same edge.
- rvalid never depends on rready. While rvalid&&!rready, rid/rdata/rresp/rlast held stable.
- cnt never wraps within a burst; len=0 gives single beat with rlast=1.
- Reset values: rvalid 0, rlast 0, rid 0, rdata 0, rresp 0, src_ready 0, busy 0; FIFO emptied, FSM IDLE, cnt 0.
- Reset mid-burst: all pending commands and partially sent bursts discarded; rvalid 0 after the reset edge. Both ends are reset together at system level.

## Timing
- Cmd accepted at edge 0 (FIFO empty, IDLE) → popped at edge 1 → BURST in cycle after edge 1 → first src handshake at edge 2 → rvalid=1 after edge 2. Minimum cmd-to-rvalid: 2 edges.
- Steady state with src_valid=1, rready=1: one beat per cycle, including across back-to-back bursts.
- src_data to rdata: 1 cycle registered.
- Simultaneous cmd push and FSM pop: both take effect; count unchanged.

## Configuration
- AXI_RD_SKID_EN defined: 2-entry skid output buffer; src_ready = BURST && skid entry empty, fully registered (no combinational rready→src_ready path); full throughput retained; beat order preserved.
- Undefined: single output register; src_ready = BURST && (!rvalid || rready), combinational from rready.
- Port list, reset values, and beat sequence identical in both builds; only src_ready timing under backpressure differs.

## Test plan
- cmd id=0x5A len=3 err=0; src words 0x100–0x103 continuous; rready=1 → 4 beats rid=0x5A, rdata 0x100..0x103, rresp=0, rlast only on beat 4, first rvalid after edge 2.
- Same burst, rready pattern 1,0,1,0… → rdata/rid/rlast stable whenever rvalid&&!rready; exactly 4 beats, no loss or duplication.
- Cmds (id 1, len 0) then (id 2, len 1) queued; src_valid=1, rready=1 → 3 consecutive beats, no idle cycle; rlast on beats 1 and 3.
- CMD_DEPTH=4, src_valid=0: push 6 cmds → 5 accepted (1 in FSM, 4 in FIFO); cmd_ready=0 holds the 6th until first burst completes.
- cmd err=1 len=1 → 2 beats rresp=2'b10, rlast on beat 2; following cmd err=0 → rresp=2'b00.
- rst pulsed after 2 of 4 beats → rvalid=0, busy=0 after edge; fresh cmd id=3 len=0 → single beat rid=3, rlast=1.
